ifu_fetch: RTL and testbench

- Parametrised next-generation instruction fetch unit that replaces the free-running PC plus asynchronous ROM.
- Owns the fetch PC and issues in-order requests to an instruction memory port with a valid/ready handshake and variable latency.
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- Supports a redirect input (branch/jump/trap) that retargets the PC, flushes the buffer and discards stale in-flight responses.

---
 rtl/ifu_fetch.sv | 131 +++++++++++++
 tb/tb_ifu_fetch.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited in-order memory requests feeding a DEPTH-entry
// instruction FIFO. Define IFU_MISALIGN_CHECK_EN to halt fetch after a misaligned redirect.
module ifu_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VAL = 32'h80000000,
    parameter int              DEPTH     = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0]     CREDITS = CW1'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic            credit_ok;
    logic            halt;
    logic            req_fire;
    logic            rsp_stale;
    logic            push;
    logic            pop;

    // Every in-flight request owns a FIFO slot, so responses never need back-pressure.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < CREDITS;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign_q;
    assign halt     = misalign_q;
    assign misalign = misalign_q;
`else
    assign halt     = 1'b0;
    assign misalign = 1'b0;
`endif

    assign imem_req_valid = !rst && !redirect_valid && credit_ok && !halt;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_stale      = redirect_valid || (drop_cnt != '0);
    assign push           = imem_rsp_valid && !rsp_stale;
    assign inst_valid     = (count != '0);
    assign pop            = inst_valid && inst_ready && !redirect_valid;
    assign inst_data      = data_mem[rd_ptr];
    assign inst_pc        = pc_mem[rd_ptr];

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !imem_rsp_valid)
            outstanding_next = outstanding + CW'(1);
        else if (!req_fire && imem_rsp_valid)
            outstanding_next = outstanding - CW'(1);
    end

    // A redirect flushes the FIFO and marks everything still in flight as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_VAL;
            rsp_pc      <= RESET_VAL;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= outstanding_next;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire)
                    pc <= pc + STEP;
                if (imem_rsp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    rsp_pc <= rsp_pc + STEP;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // Sticky until a later aligned redirect; stale responses keep draining meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (redirect_valid)
            misalign_q <= (redirect_pc[1:0] != 2'b00);
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch with a variable-latency in-order memory model.
module tb_ifu_fetch;
    localparam logic [31:0] BASE = 32'h80000000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int cyc = 0;
    int req_count = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5AC3C3;
    endfunction

    // Memory answers in order, lat cycles after acceptance, and is reset alongside the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_addr.delete();
            q_due.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_req_addr);
                q_due.push_back(cyc + lat - 1);
                req_count++;
            end
            if (q_due.size() != 0 && q_due[0] <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
            cyc++;
        end
    end

    task automatic do_reset(input int latency);
        @(negedge clk);
        rst = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        lat = latency;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (imem_req_addr !== BASE) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_req_addr, BASE); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset(1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_first_empty: got %b expected 0", inst_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = BASE + 32'(4 * i);
            checks++; if (inst_valid !== 1'b1 || inst_pc !== exp) begin errors++; $display("[TB] FAIL stream_pc%0d: got v=%b pc=%h expected v=1 pc=%h", i, inst_valid, inst_pc, exp); end
            checks++; if (inst_data !== mem_word(exp)) begin errors++; $display("[TB] FAIL stream_data%0d: got %h expected %h", i, inst_data, mem_word(exp)); end
        end
    endtask

    task automatic test_backpressure();
        int start;
        logic [31:0] exp;
        do_reset(1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        start = req_count;
        repeat (10) @(negedge clk);
        checks++; if (req_count - start !== 4) begin errors++; $display("[TB] FAIL bp_req_count: got %0d expected 4", req_count - start); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_stopped: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== BASE) begin errors++; $display("[TB] FAIL bp_head: got v=%b pc=%h expected v=1 pc=%h", inst_valid, inst_pc, BASE); end
        inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE + 32'h10) begin errors++; $display("[TB] FAIL bp_resume: got v=%b addr=%h expected v=1 addr=%h", imem_req_valid, imem_req_addr, BASE + 32'h10); end
        for (int k = 1; k < 6; k++) begin
            if (k > 1) @(negedge clk);
            exp = BASE + 32'(4 * k);
            checks++; if (inst_valid !== 1'b1 || inst_pc !== exp || inst_data !== mem_word(exp)) begin errors++; $display("[TB] FAIL bp_drain%0d: got v=%b pc=%h data=%h expected pc=%h data=%h", k, inst_valid, inst_pc, inst_data, exp, mem_word(exp)); end
        end
    endtask

    task automatic test_redirect_stale();
        logic [31:0] tgt;
        tgt = 32'h80000100;
        do_reset(4);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_req_suppressed: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== tgt) begin errors++; $display("[TB] FAIL stale_new_addr: got v=%b addr=%h expected v=1 addr=%h", imem_req_valid, imem_req_addr, tgt); end
        checks++; if (dut.drop_cnt !== 3'd3) begin errors++; $display("[TB] FAIL stale_drop_cnt: got %0d expected 3", dut.drop_cnt); end
        for (int c = 4; c < 9; c++) begin
            if (c > 4) @(negedge clk);
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_leak_c%0d: got v=%b pc=%h expected v=0", c, inst_valid, inst_pc); end
        end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== tgt || inst_data !== mem_word(tgt)) begin errors++; $display("[TB] FAIL stale_first_out: got v=%b pc=%h data=%h expected pc=%h data=%h", inst_valid, inst_pc, inst_data, tgt, mem_word(tgt)); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== tgt + 32'h4) begin errors++; $display("[TB] FAIL stale_second_out: got v=%b pc=%h expected pc=%h", inst_valid, inst_pc, tgt + 32'h4); end
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] tgt;
        tgt = 32'h80000200;
        do_reset(3);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_setup: got req_v=%b rsp_v=%b expected req_v=0 rsp_v=1", imem_req_valid, imem_rsp_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (dut.drop_cnt !== 3'd2) begin errors++; $display("[TB] FAIL same_cycle_drop_cnt: got %0d expected 2", dut.drop_cnt); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== tgt) begin errors++; $display("[TB] FAIL same_cycle_addr: got v=%b addr=%h expected v=1 addr=%h", imem_req_valid, imem_req_addr, tgt); end
        for (int c = 4; c < 8; c++) begin
            if (c > 4) @(negedge clk);
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_leak_c%0d: got v=%b pc=%h expected v=0", c, inst_valid, inst_pc); end
        end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== tgt || inst_data !== mem_word(tgt)) begin errors++; $display("[TB] FAIL same_cycle_out0: got v=%b pc=%h data=%h expected pc=%h", inst_valid, inst_pc, inst_data, tgt); end
        @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== tgt + 32'h4) begin errors++; $display("[TB] FAIL same_cycle_out1: got v=%b pc=%h expected pc=%h", inst_valid, inst_pc, tgt + 32'h4); end
    endtask

    task automatic test_flush();
        logic [31:0] tgt;
        tgt = 32'h80000300;
        do_reset(1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty: got v=%b pc=%h expected v=0", inst_valid, inst_pc); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== tgt) begin errors++; $display("[TB] FAIL flush_addr: got v=%b addr=%h expected v=1 addr=%h", imem_req_valid, imem_req_addr, tgt); end
        repeat (2) @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== tgt) begin errors++; $display("[TB] FAIL flush_first_out: got v=%b pc=%h expected pc=%h", inst_valid, inst_pc, tgt); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset(1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFFFFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = 32'hFFFFFFF8 + 32'(4 * i);
            checks++; if (inst_valid !== 1'b1 || inst_pc !== exp || inst_data !== mem_word(exp)) begin errors++; $display("[TB] FAIL wrap_pc%0d: got v=%b pc=%h data=%h expected pc=%h data=%h", i, inst_valid, inst_pc, inst_data, exp, mem_word(exp)); end
        end
    endtask

    task automatic test_stall_reset();
        int start;
        do_reset(1);
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        start = req_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== BASE) begin errors++; $display("[TB] FAIL stall_addr%0d: got v=%b addr=%h expected v=1 addr=%h", i, imem_req_valid, imem_req_addr, BASE); end
        end
        checks++; if (req_count - start !== 0) begin errors++; $display("[TB] FAIL stall_no_fire: got %0d expected 0", req_count - start); end
        imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== BASE + 32'h4 || imem_req_addr === BASE) begin errors++; $display("[TB] FAIL stall_running: got v=%b pc=%h addr=%h expected v=1 pc=%h", inst_valid, inst_pc, imem_req_addr, BASE + 32'h4); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs: got inst_v=%b req_v=%b mis=%b expected 0 0 0", inst_valid, imem_req_valid, misalign); end
        checks++; if (imem_req_addr !== BASE) begin errors++; $display("[TB] FAIL midreset_pc: got %h expected %h", imem_req_addr, BASE); end
    endtask

`ifdef IFU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        int start;
        logic [31:0] tgt;
        tgt = 32'h80000200;
        do_reset(1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80000102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (misalign !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL misalign_set: got mis=%b req_v=%b expected 1 0", misalign, imem_req_valid); end
        start = req_count;
        repeat (3) @(negedge clk);
        checks++; if (req_count - start !== 0 || misalign !== 1'b1) begin errors++; $display("[TB] FAIL misalign_halt: got reqs=%0d mis=%b expected 0 1", req_count - start, misalign); end
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (misalign !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== tgt) begin errors++; $display("[TB] FAIL misalign_clear: got mis=%b v=%b addr=%h expected 0 1 %h", misalign, imem_req_valid, imem_req_addr, tgt); end
        repeat (2) @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== tgt) begin errors++; $display("[TB] FAIL misalign_resume: got v=%b pc=%h expected pc=%h", inst_valid, inst_pc, tgt); end
    endtask
`else
    task automatic test_misalign_disabled();
        logic [31:0] tgt;
        tgt = 32'h80000102;
        do_reset(1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (misalign !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== tgt) begin errors++; $display("[TB] FAIL unaligned_issue: got mis=%b v=%b addr=%h expected 0 1 %h", misalign, imem_req_valid, imem_req_addr, tgt); end
        repeat (2) @(negedge clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== tgt || inst_data !== mem_word(tgt)) begin errors++; $display("[TB] FAIL unaligned_out: got v=%b pc=%h data=%h expected pc=%h", inst_valid, inst_pc, inst_data, tgt); end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_same_cycle();
        test_flush();
        test_wrap();
        test_stall_reset();
`ifdef IFU_MISALIGN_CHECK_EN
        test_misalign();
`else
        test_misalign_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
